// File: rtl/fsm_mealy_decoder.sv
// Receive-side decoder for the 2-bit Color Mealy encoder (states Red/Blue).
// It tracks the encoder state from the code stream and recovers the input
// symbols. It flags codes that are illegal for the tracked state, and it
// resynchronises on code 1, which the encoder can only produce from Red.
module fsm_mealy_decoder #(
  parameter int ERR_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 code_valid,
  input  logic [1:0]           code_data,
  output logic                 code_ready,
  output logic                 dec_valid,
  output logic [1:0]           dec_data,
  input  logic                 dec_ready,
  output logic                 err,
  output logic [ERR_WIDTH-1:0] err_count,
  output logic                 in_sync
);

  localparam logic [1:0] ST_RED    = 2'd0;
  localparam logic [1:0] ST_BLUE   = 2'd1;
  localparam logic [1:0] ST_RESYNC = 2'd2;

  localparam logic [ERR_WIDTH-1:0] ERR_ONE = {{(ERR_WIDTH-1){1'b0}}, 1'b1};

  // Saturating increment; the count sticks at all-ones.
  function automatic logic [ERR_WIDTH-1:0] sat_inc(input logic [ERR_WIDTH-1:0] v);
    return (&v) ? v : v + ERR_ONE;
  endfunction

  logic [1:0]           state_q, state_d;
  logic                 dec_valid_q, dec_valid_d;
  logic [1:0]           dec_data_q, dec_data_d;
  logic                 err_q, err_d;
  logic [ERR_WIDTH-1:0] err_count_q, err_count_d;
  logic                 in_sync_q, in_sync_d;

  logic                 acc;
  logic                 emit;
  logic                 illegal;
  logic [1:0]           sym;

  assign code_ready = !dec_valid_q || dec_ready;
  assign acc        = code_valid && code_ready;

  // Decode the accepted code against the tracked encoder state.
  always_comb begin
    state_d = state_q;
    emit    = 1'b0;
    illegal = 1'b0;
    sym     = 2'h0;
    if (acc) begin
      case (state_q)
        ST_RED: begin
          if (code_data == 2'h2) begin
            emit = 1'b1;
            sym  = 2'h0;
          end else if (code_data == 2'h1) begin
            emit    = 1'b1;
            sym     = 2'h1;
            state_d = ST_BLUE;
          end else begin
            illegal = 1'b1;
            state_d = ST_RESYNC;
          end
        end
        ST_BLUE: begin
          if (code_data == 2'h2) begin
            emit    = 1'b1;
            sym     = 2'h1;
            state_d = ST_RED;
          end else begin
            illegal = 1'b1;
            state_d = ST_RESYNC;
          end
        end
        default: begin
          // Only code 1 pins down the encoder state; everything else is dropped quietly.
          if (code_data == 2'h1) begin
            emit    = 1'b1;
            sym     = 2'h1;
            state_d = ST_BLUE;
          end
        end
      endcase
    end
  end

  // Output register, error pulse, saturating counter and sync flag next-state.
  always_comb begin
    dec_valid_d = dec_valid_q;
    dec_data_d  = dec_data_q;
    if (emit) begin
      dec_valid_d = 1'b1;
      dec_data_d  = sym;
    end else if (dec_valid_q && dec_ready) begin
      dec_valid_d = 1'b0;
    end
    err_d       = illegal;
    err_count_d = illegal ? sat_inc(err_count_q) : err_count_q;
    in_sync_d   = (state_d != ST_RESYNC);
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_RED;
      dec_valid_q <= 1'b0;
      dec_data_q  <= 2'h0;
      err_q       <= 1'b0;
      err_count_q <= '0;
      in_sync_q   <= 1'b1;
    end else begin
      state_q     <= state_d;
      dec_valid_q <= dec_valid_d;
      dec_data_q  <= dec_data_d;
      err_q       <= err_d;
      err_count_q <= err_count_d;
      in_sync_q   <= in_sync_d;
    end
  end

  assign dec_valid = dec_valid_q;
  assign dec_data  = dec_data_q;
  assign err       = err_q;
  assign err_count = err_count_q;
  assign in_sync   = in_sync_q;

endmodule

// File: tb/tb_fsm_mealy_decoder.sv
// Testbench for fsm_mealy_decoder. The reference model inverts the Color
// encoder's transition table and keeps the pending symbols in a queue.
module tb_fsm_mealy_decoder;

  localparam int EW = 2;
  localparam int CNT_MAX = (1 << EW) - 1;

  logic          clk;
  logic          rst_n;
  logic          code_valid;
  logic [1:0]    code_data;
  logic          code_ready;
  logic          dec_valid;
  logic [1:0]    dec_data;
  logic          dec_ready;
  logic          err;
  logic [EW-1:0] err_count;
  logic          in_sync;

  fsm_mealy_decoder #(.ERR_WIDTH(EW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .code_valid (code_valid),
    .code_data  (code_data),
    .code_ready (code_ready),
    .dec_valid  (dec_valid),
    .dec_data   (dec_data),
    .dec_ready  (dec_ready),
    .err        (err),
    .err_count  (err_count),
    .in_sync    (in_sync)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference model state
  bit       m_blue;   // encoder colour: 0 = Red, 1 = Blue
  bit       m_lost;   // decoder has lost track of the encoder
  bit       m_err;
  int       m_cnt;
  bit [1:0] exp_q[$];

  // Values captured by cycle() for the test tasks to compare
  bit       exp_ready, obs_ready;
  bit       did_pop;
  bit [1:0] exp_pop, obs_pop;

  // Encoder transition table: code produced from a colour for an input symbol, -1 if none.
  function automatic int enc_code(input bit blue, input int s);
    if (!blue && s == 0) return 2;
    if (!blue && s == 1) return 1;
    if (blue && s == 1)  return 2;
    return -1;
  endfunction

  function automatic bit [4:0] exp_status();
    bit [1:0] c2;
    c2 = m_cnt[1:0];
    return {exp_q.size() != 0, m_err, c2, !m_lost};
  endfunction

  task automatic model_reset();
    m_blue = 1'b0;
    m_lost = 1'b0;
    m_err  = 1'b0;
    m_cnt  = 0;
    exp_q.delete();
  endtask

  // Drive one cycle, capture handshake/pop observations, advance the model.
  task automatic cycle(input bit v, input bit [1:0] c, input bit r);
    bit found;
    code_valid = v;
    code_data  = c;
    dec_ready  = r;
    @(negedge clk);
    exp_ready = (exp_q.size() == 0) || r;
    obs_ready = code_ready;
    did_pop   = (exp_q.size() != 0) && r;
    if (did_pop) begin
      obs_pop = dec_data;
      exp_pop = exp_q.pop_front();
    end
    m_err = 1'b0;
    if (v && exp_ready) begin
      if (m_lost) begin
        if (c == 2'h1) begin
          exp_q.push_back(2'h1);
          m_blue = 1'b1;
          m_lost = 1'b0;
        end
      end else begin
        found = 1'b0;
        for (int s = 0; s < 2; s++) begin
          if (!found && enc_code(m_blue, s) == int'(c)) begin
            found = 1'b1;
            exp_q.push_back(s[1:0]);
            m_blue = m_blue ^ s[0];
          end
        end
        if (!found) begin
          m_lost = 1'b1;
          m_err  = 1'b1;
          if (m_cnt < CNT_MAX) m_cnt++;
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic hard_reset();
    code_valid = 1'b0;
    code_data  = 2'h0;
    dec_ready  = 1'b1;
    rst_n      = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    code_valid = 1'b0;
    code_data  = 2'h3;
    dec_ready  = 1'b0;
    rst_n      = 1'b0;
    #12;
    n_cmp++;
    if ({dec_valid, dec_data, err, err_count, in_sync, code_ready} !== {1'b0, 2'h0, 1'b0, 2'h0, 1'b1, 1'b1}) begin
      n_fail++;
      $display("FAIL reset_values got v=%b d=%h e=%b c=%0d s=%b r=%b want v=0 d=0 e=0 c=0 s=1 r=1",
               dec_valid, dec_data, err, err_count, in_sync, code_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    @(posedge clk);
    #1;
  endtask

  task automatic test_legal();
    bit [1:0] codes[5] = '{2'h2, 2'h1, 2'h2, 2'h2, 2'h0};
    bit [1:0] want[4]  = '{2'h0, 2'h1, 2'h1, 2'h0};
    int k = 0;
    for (int i = 0; i < 5; i++) begin
      cycle(i < 4, codes[i], 1'b1);
      if (did_pop) begin
        n_cmp++;
        if (obs_pop !== want[k]) begin
          n_fail++;
          $display("FAIL legal_sym%0d got %h want %h", k, obs_pop, want[k]);
        end
        k++;
      end
      n_cmp++;
      if ({dec_valid, err, err_count, in_sync} !== exp_status()) begin
        n_fail++;
        $display("FAIL legal_status cyc%0d got %b want %b", i, {dec_valid, err, err_count, in_sync}, exp_status());
      end
      if (dec_valid) begin
        n_cmp++;
        if (dec_data !== exp_q[0]) begin
          n_fail++;
          $display("FAIL legal_data cyc%0d got %h want %h", i, dec_data, exp_q[0]);
        end
      end
    end
  endtask

  task automatic test_illegal_blue();
    bit [1:0] codes[3] = '{2'h1, 2'h1, 2'h0};
    for (int i = 0; i < 3; i++) begin
      cycle(i < 2, codes[i], 1'b1);
      if (did_pop) begin
        n_cmp++;
        if (obs_pop !== exp_pop) begin
          n_fail++;
          $display("FAIL illegal_pop got %h want %h", obs_pop, exp_pop);
        end
      end
      n_cmp++;
      if ({dec_valid, err, err_count, in_sync} !== exp_status()) begin
        n_fail++;
        $display("FAIL illegal_status cyc%0d got %b want %b", i, {dec_valid, err, err_count, in_sync}, exp_status());
      end
    end
    n_cmp++;
    if ({err_count, in_sync} !== {2'd1, 1'b0}) begin
      n_fail++;
      $display("FAIL illegal_final got cnt=%0d sync=%b want cnt=1 sync=0", err_count, in_sync);
    end
  endtask

  task automatic test_resync();
    bit [1:0] codes[6] = '{2'h2, 2'h0, 2'h3, 2'h1, 2'h2, 2'h0};
    for (int i = 0; i < 6; i++) begin
      cycle(i < 5, codes[i], 1'b1);
      if (did_pop) begin
        n_cmp++;
        if (obs_pop !== exp_pop) begin
          n_fail++;
          $display("FAIL resync_pop got %h want %h", obs_pop, exp_pop);
        end
      end
      n_cmp++;
      if ({dec_valid, err, err_count, in_sync} !== exp_status()) begin
        n_fail++;
        $display("FAIL resync_status cyc%0d got %b want %b", i, {dec_valid, err, err_count, in_sync}, exp_status());
      end
    end
  endtask

  task automatic test_backpressure();
    bit       v[7]     = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    bit [1:0] codes[7] = '{2'h2, 2'h1, 2'h1, 2'h1, 2'h2, 2'h0, 2'h0};
    bit       r[7]     = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    hard_reset();
    for (int i = 0; i < 7; i++) begin
      cycle(v[i], codes[i], r[i]);
      n_cmp++;
      if (obs_ready !== exp_ready) begin
        n_fail++;
        $display("FAIL bp_code_ready cyc%0d got %b want %b", i, obs_ready, exp_ready);
      end
      if (did_pop) begin
        n_cmp++;
        if (obs_pop !== exp_pop) begin
          n_fail++;
          $display("FAIL bp_pop cyc%0d got %h want %h", i, obs_pop, exp_pop);
        end
      end
      n_cmp++;
      if ({dec_valid, err, err_count, in_sync} !== exp_status()) begin
        n_fail++;
        $display("FAIL bp_status cyc%0d got %b want %b", i, {dec_valid, err, err_count, in_sync}, exp_status());
      end
      if (dec_valid) begin
        n_cmp++;
        if (dec_data !== exp_q[0]) begin
          n_fail++;
          $display("FAIL bp_data cyc%0d got %h want %h", i, dec_data, exp_q[0]);
        end
      end
    end
  endtask

  task automatic test_saturation();
    bit [1:0] want_cnt[5] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
    hard_reset();
    for (int i = 0; i < 5; i++) begin
      cycle(1'b1, 2'h0, 1'b1);
      n_cmp++;
      if ({err, err_count} !== {1'b1, want_cnt[i]}) begin
        n_fail++;
        $display("FAIL sat_illegal%0d got err=%b cnt=%0d want err=1 cnt=%0d", i, err, err_count, want_cnt[i]);
      end
      cycle(1'b1, 2'h1, 1'b1);
      n_cmp++;
      if ({dec_valid, err, err_count, in_sync} !== exp_status()) begin
        n_fail++;
        $display("FAIL sat_resync%0d got %b want %b", i, {dec_valid, err, err_count, in_sync}, exp_status());
      end
    end
  endtask

  task automatic test_random();
    bit v, r;
    bit [1:0] c;
    hard_reset();
    for (int i = 0; i < 400; i++) begin
      v = ($urandom_range(0, 3) != 0);
      c = 2'($urandom_range(0, 3));
      r = ($urandom_range(0, 3) != 0);
      cycle(v, c, r);
      n_cmp++;
      if (obs_ready !== exp_ready) begin
        n_fail++;
        $display("FAIL rnd_code_ready cyc%0d got %b want %b", i, obs_ready, exp_ready);
      end
      if (did_pop) begin
        n_cmp++;
        if (obs_pop !== exp_pop) begin
          n_fail++;
          $display("FAIL rnd_pop cyc%0d got %h want %h", i, obs_pop, exp_pop);
        end
      end
      n_cmp++;
      if ({dec_valid, err, err_count, in_sync} !== exp_status()) begin
        n_fail++;
        $display("FAIL rnd_status cyc%0d got %b want %b", i, {dec_valid, err, err_count, in_sync}, exp_status());
      end
    end
  endtask

  task automatic test_async_reset();
    hard_reset();
    cycle(1'b1, 2'h1, 1'b0);
    cycle(1'b1, 2'h0, 1'b0);
    n_cmp++;
    if ({dec_valid, err_count} !== {1'b1, 2'd0}) begin
      n_fail++;
      $display("FAIL arst_setup got v=%b cnt=%0d want v=1 cnt=0", dec_valid, err_count);
    end
    cycle(1'b0, 2'h0, 1'b1);
    cycle(1'b1, 2'h0, 1'b1);
    cycle(1'b1, 2'h1, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({dec_valid, dec_data, err, err_count, in_sync, code_ready} !== {1'b0, 2'h0, 1'b0, 2'h0, 1'b1, 1'b1}) begin
      n_fail++;
      $display("FAIL arst_values got v=%b d=%h e=%b c=%0d s=%b r=%b want v=0 d=0 e=0 c=0 s=1 r=1",
               dec_valid, dec_data, err, err_count, in_sync, code_ready);
    end
    code_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    @(posedge clk);
    #1;
    cycle(1'b1, 2'h2, 1'b0);
    n_cmp++;
    if ({dec_valid, dec_data, in_sync, err} !== {1'b1, 2'h0, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL arst_red got v=%b d=%h s=%b e=%b want v=1 d=0 s=1 e=0", dec_valid, dec_data, in_sync, err);
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_legal();
    test_illegal_blue();
    test_resync();
    test_backpressure();
    test_saturation();
    test_random();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/fsm_mealy_decoder.md
# fsm_mealy_decoder

Receive-side decoder for the 2-bit Color Mealy encoder, whose states are Blue and Red and whose reset state is Red. The block accepts the encoder's output code stream, tracks the encoder's state in lockstep and recovers the original 2-bit input symbols. It flags codes that are illegal for the tracked state and resynchronises on the first unambiguous code. It sits between the link sampler upstream and the symbol consumer downstream, with valid/ready handshakes on both sides.

## Interface
- ERR_WIDTH, 8, width of the saturating error counter
- clk  input  1  single clock; all state updates on its rising edge
- rst_n  input  1  asynchronous active-low reset
- code_valid  input  1  upstream code present
- code_data  input  2  encoder output code
- code_ready  output  1  decoder accepts a code this cycle
- dec_valid  output  1  recovered symbol present
- dec_data  output  2  recovered encoder input symbol (2'h0 or 2'h1)
- dec_ready  input  1  downstream accepts the symbol
- err  output  1  one-cycle pulse: illegal code consumed
- err_count  output  ERR_WIDTH  saturating count of illegal codes
- in_sync  output  1  high when the tracked state is Red or Blue, low in RESYNC

## Operation
- Tracked-state FSM with states RED, BLUE and RESYNC. It resets to RED, which matches the encoder's reset state.
- Accept condition: acc = code_valid && code_ready, where code_ready = !dec_valid || dec_ready. The ready rule is the same in every state.
- On acc, decode code_data as follows:
  - RED, code 2'h2: emit dec_data = 2'h0 and stay in RED.
  - RED, code 2'h1: emit 2'h1 and go to BLUE.
  - BLUE, code 2'h2: emit 2'h1 and go to RED.
  - RED with code 2'h0 or 2'h3: illegal; go to RESYNC.
  - BLUE with code 2'h0, 2'h1 or 2'h3: illegal; go to RESYNC.
  - RESYNC, code 2'h1: emit 2'h1 and go to BLUE. Code 2'h1 is legal only from Red, so it fixes the state.
  - RESYNC, any other code: discard silently and stay in RESYNC. This produces no output, no err pulse and no count increment.
- On an illegal code:
  - No symbol is emitted.
  - err pulses high in the cycle after acceptance.
  - err_count increments, saturating at 2^ERR_WIDTH-1.
- Output register:
  - When acc produces a symbol, dec_valid is set and dec_data is loaded.
  - The register clears on dec_ready && dec_valid, unless it is reloaded in the same cycle.
  - dec_data is held stable while dec_valid && !dec_ready.
- in_sync is a registered decode of the FSM state: 0 in RESYNC, 1 otherwise.
- An accepted code that emits nothing (illegal, or discarded in RESYNC) leaves the output register untouched.

## Timing
- Reset values: FSM = RED, dec_valid = 0, dec_data = 2'h0, err = 0, err_count = 0, in_sync = 1. code_ready = 1 because dec_valid = 0.
- Reset is asynchronous on assertion and is sampled synchronously on release.
- Latency: a code accepted at edge N gives dec_valid (or err) high after edge N.
- Throughput: one code per cycle while dec_ready stays high.
- Backpressure: with dec_valid = 1 and dec_ready = 0, code_ready = 0 and no code is consumed. FSM, counter and output all hold.
- Simultaneous events:
  - Pop and push in the same cycle: the register reloads with the new symbol and dec_valid stays 1.
  - Illegal code while an old symbol drains: the old symbol pops normally, dec_valid drops to 0, and err pulses.
- err_count at its maximum stays at its maximum. err still pulses.
- Reset mid-stream: any pending dec_valid symbol is dropped, the FSM returns to RED and the counter clears.
- code_data is ignored whenever acc = 0.

## Test plan
- Legal stream: after reset, send codes 2,1,2,2 with dec_ready = 1. Expect dec_data 0,1,1,0, each one cycle after its code, with in_sync = 1 throughout and err never high.
- Illegal code from BLUE: send 1 then 1. Expect output 1, then an err pulse, err_count = 1, in_sync = 0 and no second symbol.
- Resync: from RESYNC send 2,0,3,1,2. Expect the first three discarded with no err, then outputs 1,1 and in_sync = 1 after the code 1.
- Backpressure: hold dec_ready = 0 with 3 codes queued. Expect code_ready = 0 after the first accept and dec_data stable. Release dec_ready and expect the remaining symbols in order, one per cycle.
- Saturation: with ERR_WIDTH = 2, send 5 illegal codes, resyncing with code 1 after each. Expect err_count 1,2,3,3,3 and five err pulses.
- Async reset mid-stream: assert rst_n low between edges while dec_valid = 1. Expect all outputs at reset values immediately. After release, code 2 decodes to 0, which shows the FSM is back in RED.
